// File: rtl/pixel_pkg.sv
// Shared constants and pixel types for the layer mixer.
package pixel_pkg;

  localparam int unsigned RGB_W      = 12;
  localparam int unsigned CH_W       = 4;
  localparam int unsigned PIPE_DEPTH = 3;

  localparam logic [RGB_W-1:0] KEY_COLOR = 12'hF0F;
  localparam logic [RGB_W-1:0] BG_COLOR  = 12'h000;
  localparam logic [RGB_W-1:0] BLACK     = 12'h000;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/sync_delay.sv
// N-cycle shift register with a configurable reset value, used to align
// control and sync bits with the memory read latency.
module sync_delay #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [N];

  // Shift chain; every stage loads RST_VAL on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < int'(N); i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/pixel_mixer.sv
// Three-stage priority mixer of NUM_LAYERS sprite/terrain layers with a
// colour-keyed transparency and a per-frame layer 0/1 collision flag.
module pixel_mixer #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned ADDR_W     = 17,
  parameter logic [pixel_pkg::RGB_W-1:0] KEY_COLOR = pixel_pkg::KEY_COLOR,
  parameter logic [pixel_pkg::RGB_W-1:0] BG_COLOR  = pixel_pkg::BG_COLOR
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  input  logic                                 hsync_in,
  input  logic                                 vsync_in,
  input  logic [NUM_LAYERS-1:0]                layer_en,
  input  logic [NUM_LAYERS*ADDR_W-1:0]         layer_addr,
  output logic [NUM_LAYERS*ADDR_W-1:0]         mem_addr,
  input  logic [NUM_LAYERS*pixel_pkg::RGB_W-1:0] mem_data,
  output logic [pixel_pkg::CH_W-1:0]           vga_r,
  output logic [pixel_pkg::CH_W-1:0]           vga_g,
  output logic [pixel_pkg::CH_W-1:0]           vga_b,
  output logic                                 hsync_out,
  output logic                                 vsync_out,
  output logic                                 collision
);

  import pixel_pkg::*;

  localparam int unsigned S2_DEPTH = PIPE_DEPTH - 1;
  localparam int unsigned CTRL_W   = NUM_LAYERS + 1;

  logic [NUM_LAYERS-1:0] en_s2;
  logic                  valid_s2;
  logic                  hs_s2;
  logic                  vs_s2;
  logic [NUM_LAYERS-1:0] opaque_c;
  rgb_t                  pix_c;
  logic                  vs_rise_c;

  // Enable/valid delayed to line up with returning memory data.
  sync_delay #(
    .W       (CTRL_W),
    .N       (S2_DEPTH),
    .RST_VAL (CTRL_W'(0))
  ) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .d   ({valid_in, layer_en}),
    .q   ({valid_s2, en_s2})
  );

  // Syncs delayed alongside; idle-high so reset looks like no sync pulse.
  sync_delay #(
    .W       (2),
    .N       (S2_DEPTH),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   ({hsync_in, vsync_in}),
    .q   ({hs_s2, vs_s2})
  );

  // Stage 1: present layer addresses to the frame memories every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_addr <= '0;
    else     mem_addr <= layer_addr;
  end

  // A layer is opaque when it hits and its texel is not the key colour.
  always_comb begin
    opaque_c = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      opaque_c[i] = en_s2[i] && (mem_data[i*RGB_W +: RGB_W] != KEY_COLOR);
    end
  end

  // Lowest-index opaque layer wins; blanking overrides everything.
  always_comb begin
    pix_c = rgb_t'(BG_COLOR);
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (opaque_c[i]) pix_c = rgb_t'(mem_data[i*RGB_W +: RGB_W]);
    end
    if (!valid_s2) pix_c = rgb_t'(BLACK);
  end

  // Stage 3: registered colour and syncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vga_r     <= pix_c.r;
      vga_g     <= pix_c.g;
      vga_b     <= pix_c.b;
      hsync_out <= hs_s2;
      vsync_out <= vs_s2;
    end
  end

  // vsync_out holds the previous stage-2 vsync, giving the edge for free.
  assign vs_rise_c = vs_s2 & ~vsync_out;

  if (NUM_LAYERS >= 2) begin : g_coll
    logic overlap;
    logic hit_c;

    assign hit_c = valid_s2 & opaque_c[0] & opaque_c[1];

    // Frame overlap accumulator; an overlap on the edge belongs to the new frame.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        overlap   <= 1'b0;
        collision <= 1'b0;
      end else if (vs_rise_c) begin
        collision <= overlap;
        overlap   <= hit_c;
      end else begin
        overlap   <= overlap | hit_c;
      end
    end
  end else begin : g_no_coll
    assign collision = 1'b0;
  end

endmodule

// File: doc/pixel_mixer.md
PIXEL_MIXER -- requirements
Module: pixel_mixer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sprite/terrain layers mixed.
REQ-002 SHALL have parameter ADDR_W, default 17, per-layer frame-memory address width.
REQ-003 SHALL have parameter KEY_COLOR, default 12'hF0F, transparent colour key.
REQ-004 SHALL have parameter BG_COLOR, default 12'h000, colour shown where no layer is opaque.
REQ-005 SHALL have port clk, input, 1, pixel clock; one pixel per cycle.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port valid_in, input, 1, VGA active-area flag for current pixel.
REQ-008 SHALL have port hsync_in, input, 1, and port vsync_in, input, 1, sync from VGA controller.
REQ-009 SHALL have port layer_en, input, NUM_LAYERS, per-layer hit flag from address generators.
REQ-010 SHALL have port layer_addr, input, NUM_LAYERS*ADDR_W, packed per-layer memory addresses, layer i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port mem_addr, output, NUM_LAYERS*ADDR_W, registered addresses to block memories.
REQ-012 SHALL have port mem_data, input, NUM_LAYERS*12, per-layer RGB444 data, one cycle after mem_addr.
REQ-013 SHALL have ports vga_r, vga_g, vga_b, output, 4 each, registered pixel colour.
REQ-014 SHALL have ports hsync_out, vsync_out, output, 1 each, sync aligned with colour.
REQ-015 SHALL have port collision, output, 1, layer 0 / layer 1 overlap flag of previous frame.

Function
REQ-016 SHALL form a 3-stage pipeline: S1 registers layer_addr to mem_addr plus en/valid/sync; S2 holds delayed en/valid/sync while mem_data returns; S3 registers colour and sync outputs.
REQ-017 SHALL give exactly 3 cycles latency from valid_in/hsync_in/vsync_in/layer_en to vga_*/hsync_out/vsync_out.
REQ-018 SHALL treat layer i opaque in S2 iff delayed layer_en[i]=1 and mem_data for i != KEY_COLOR.
REQ-019 SHALL select the lowest-index opaque layer (layer 0 highest priority).
REQ-020 SHALL output BG_COLOR when no layer is opaque and delayed valid=1.
REQ-021 SHALL output 12'h000 when delayed valid=0, regardless of layer_en or mem_data.
REQ-022 SHALL register mem_addr unconditionally every cycle, including when layer_en=0.
REQ-023 SHALL set an internal overlap flag when layers 0 and 1 are both opaque at a valid pixel in S2.
REQ-024 SHALL, on rising edge of delayed vsync_in (vsync_in 0->1 seen in S2), copy the overlap flag into collision and clear the overlap flag in the same cycle.
REQ-025 SHALL, if an overlap occurs in the same cycle as that vsync edge, count it toward the new frame (flag set after clear).
REQ-026 SHALL hold collision constant between vsync rising edges.
REQ-027 SHALL ignore NUM_LAYERS<2 for collision (collision tied 0).

Reset
REQ-028 SHALL asynchronously clear on rst: mem_addr=0, all pipeline en/valid=0, vga_r/g/b=0, collision=0, overlap flag=0.
REQ-029 SHALL drive hsync_out=1 and vsync_out=1 (inactive, active-low VGA) during reset and reset all delayed sync bits to 1.
REQ-030 SHALL, after rst deasserts mid-frame, output black until valid pixels propagate 3 cycles; no spurious collision update from reset-to-sync transition.

Structure
REQ-031 SHALL take KEY_COLOR, BG_COLOR, RGB width 12 and pipeline depth 3 from shared package pixel_pkg.
REQ-032 SHALL use one sub-module sync_delay (N-cycle shift register, reset value parameter) for valid/hsync/vsync/en alignment.

Verification
REQ-033 Layer0 en=1, data=12'hABC, valid=1 -> vga={A,B,C} exactly 3 cycles later.
REQ-034 Layer0 data=12'hF0F, layer1 en=1 data=12'h123 -> output 12'h123; all layers keyed -> BG_COLOR.
REQ-035 valid_in=0, layer0 en=1 data=12'hFFF -> output 12'h000; hsync_in pulse 0 for 96 cycles -> hsync_out 0 for 96 cycles, delayed 3.
REQ-036 Layers 0,1 opaque once in frame N -> collision=1 after next vsync rising edge, back to 0 one frame later with no overlap.
REQ-037 Assert rst mid-line with opaque layers -> outputs 0, syncs 1 immediately (asynchronous); recovery output correct 3 cycles after release.
REQ-038 Overlap coincident with vsync edge -> collision reflects prior frame, new frame flag set.
